pool_result_serializer: RTL and testbench

- Consumer of the max-pooling stage's parallel output. Captures one full pooled frame (RESULT_WIDTH x RESULT_WIDTH signed words) in a single cycle.
- Streams the frame out one element per beat, row-major, on a valid/ready interface, tagging each beat with row, column and last.
- Sits between the pooling stage and the serial dense/flatten stage.

---
 rtl/pool_result_serializer.sv | 129 ++++++++++++
 tb/tb_pool_result_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pool_result_serializer.sv
// Captures a pooled frame in one cycle and streams it row-major on valid/ready.
// Build option: define POOL_SERIALIZER_RELU_EN to clamp negative elements to 0 at capture.
module pool_result_serializer #(
  parameter  int IP_DATA_WIDTH    = 8,
  parameter  int ARRAY_WIDTH      = 3,
  parameter  int POOL_FILTER_SIZE = 2,
  parameter  int POOL_STRIDE      = 1,
  parameter  int RESULT_WIDTH     = ((ARRAY_WIDTH - POOL_FILTER_SIZE) / POOL_STRIDE) + 1,
  localparam int N_ELEM           = RESULT_WIDTH * RESULT_WIDTH,
  localparam int DW               = 2 * IP_DATA_WIDTH,
  localparam int CW               = (RESULT_WIDTH > 1) ? $clog2(RESULT_WIDTH) : 1,
  localparam int IW               = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in_vec [N_ELEM],
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_row,
  output logic [CW-1:0]        out_col,
  output logic                 out_last,
  output logic                 frame_drop
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic signed [DW-1:0]  frame_q [N_ELEM];
  logic signed [DW-1:0]  frame_d [N_ELEM];
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic signed [DW-1:0]  out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  frame_drop_q, frame_drop_d;

  function automatic logic signed [DW-1:0] clip(input logic signed [DW-1:0] v);
`ifdef POOL_SERIALIZER_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_drop_d = in_valid && (state_q == STREAM);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < N_ELEM; i++) begin
            frame_d[i] = clip(in_vec[i]);
          end
          idx_d      = '0;
          row_d      = '0;
          col_d      = '0;
          out_data_d = clip(in_vec[0]);
          out_last_d = (N_ELEM == 1);
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q == IW'(N_ELEM - 1)) begin
            idx_d      = '0;
            row_d      = '0;
            col_d      = '0;
            out_data_d = '0;
            out_last_d = 1'b0;
            state_d    = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (col_q == CW'(RESULT_WIDTH - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            // Preload the next element so out_data stays a plain register output.
            out_data_d = frame_q[idx_d];
            out_last_d = (idx_d == IW'(N_ELEM - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      frame_q      <= '{default: '0};
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == STREAM);
  assign out_data   = out_data_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_last   = out_last_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_pool_result_serializer.sv
// Scoreboard bench for pool_result_serializer (default 2x2 frame).
module tb_pool_result_serializer;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int CW = 1;

  typedef struct packed {
    logic signed [DW-1:0] data;
    logic [CW-1:0]        row;
    logic [CW-1:0]        col;
    logic                 last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] in_vec [N];
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic                 out_last;
  logic                 frame_drop;

  int    compared   = 0;
  int    mismatched = 0;
  beat_t sb_q[$];

  pool_result_serializer dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] expect_val(input logic signed [DW-1:0] v);
`ifdef POOL_SERIALIZER_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Presents a frame for the next edge and queues the first n_push expected beats.
  task automatic applyStimulus(input logic signed [DW-1:0] f [N], input int n_push);
    for (int i = 0; i < N; i++) begin
      in_vec[i] = f[i];
      if (i < n_push) sb_q.push_back(beat_t'{expect_val(f[i]), CW'(i / 2), CW'(i % 2), (i == N - 1)});
    end
    in_valid = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int c = 0; c < limit && !(sb_q.size() == 0 && in_ready); c++) tick();
    checkOutput(name, int'(sb_q.size() == 0 && in_ready), 1);
  endtask

  // Monitor: sampled on the falling edge, so a handshake seen here completes at the next rise.
  initial begin
    beat_t got;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        got = beat_t'{out_data, out_row, out_col, out_last};
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_beat", int'(got), -1);
        end else if (out_ready) begin
          checkOutput("beat", int'(got), int'(sb_q.pop_front()));
        end else begin
          checkOutput("stall_hold", int'(got), int'(sb_q[0]));
        end
      end
    end
  end

  initial begin
    logic signed [DW-1:0] f_basic [N];
    logic signed [DW-1:0] f_nine  [N];
    logic signed [DW-1:0] f_seq   [N];
    logic signed [DW-1:0] f_relu  [N];
    logic                 bp_pat  [7];

    f_basic = '{16'sd5, -16'sd3, 16'sd7, 16'sd2};
    f_nine  = '{16'sd9, 16'sd9, 16'sd9, 16'sd9};
    f_seq   = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    f_relu  = '{16'sd5, -16'sd3, 16'sd7, 16'sh8000};
    bp_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_vec[i] = '0;
    #2 rst = 1'b0;

    // Reset held with noisy inputs
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) in_vec[i] = DW'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_frame_drop", int'(frame_drop), 0);
    checkOutput("rst_out_last", int'(out_last), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", int'(in_ready), 1);
    checkOutput("post_rst_out_valid", int'(out_valid), 0);

    // Basic stream at full rate
    applyStimulus(f_basic, N);
    tick();
    in_valid = 1'b0;
    checkOutput("basic_in_ready_busy", int'(in_ready), 0);
    checkOutput("basic_first_valid", int'(out_valid), 1);
    for (int c = 0; c < N; c++) tick();
    checkOutput("basic_in_ready_after", int'(in_ready), 1);
    checkOutput("basic_queue_empty", sb_q.size(), 0);

    // Backpressure
    applyStimulus(f_basic, N);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      out_ready = bp_pat[c];
      tick();
    end
    out_ready = 1'b1;
    checkOutput("bp_in_ready_after", int'(in_ready), 1);
    checkOutput("bp_queue_empty", sb_q.size(), 0);

    // Frame arriving mid-stream is dropped, then captured after the bubble
    applyStimulus(f_basic, N);
    tick();
    checkOutput("drop_capture_edge", int'(frame_drop), 0);
    for (int i = 0; i < N; i++) in_vec[i] = f_nine[i];
    for (int c = 0; c < N; c++) begin
      tick();
      checkOutput("drop_pulse", int'(frame_drop), 1);
    end
    applyStimulus(f_nine, N);
    tick();
    in_valid = 1'b0;
    checkOutput("drop_second_capture", int'(frame_drop), 0);
    checkOutput("drop_second_busy", int'(in_ready), 0);
    wait_idle("drop_drain", 20);

    // Reset mid-stream after two beats
    applyStimulus(f_basic, 2);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_out_data", int'(out_data), 0);
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_still_idle", int'(out_valid), 0);
    applyStimulus(f_seq, N);
    tick();
    in_valid = 1'b0;
    wait_idle("midrst_drain", 20);

    // Negative elements (clamped only in the RELU build)
    applyStimulus(f_relu, N);
    tick();
    in_valid = 1'b0;
    wait_idle("relu_drain", 20);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
